// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage: ALU op codes, operand source
// selects and the registered ALU request bundle.
package alu_operand_stage_pkg;

   localparam int ALU_XLEN  = 32;
   localparam int ALU_REG_W = 5;

   localparam logic [2:0] ALU_OP_ADD = 3'd0;
   localparam logic [2:0] ALU_OP_SUB = 3'd1;
   localparam logic [2:0] ALU_OP_AND = 3'd2;
   localparam logic [2:0] ALU_OP_OR  = 3'd3;
   localparam logic [2:0] ALU_OP_XOR = 3'd4;
   localparam logic [2:0] ALU_OP_SLL = 3'd5;
   localparam logic [2:0] ALU_OP_SRL = 3'd6;
   localparam logic [2:0] ALU_OP_SLT = 3'd7;

   localparam logic [1:0] SEL_A_RS1  = 2'd0;
   localparam logic [1:0] SEL_A_PC   = 2'd1;
   localparam logic [1:0] SEL_A_ZERO = 2'd2;

   localparam logic [1:0] SEL_B_RS2  = 2'd0;
   localparam logic [1:0] SEL_B_IMM  = 2'd1;
   localparam logic [1:0] SEL_B_FOUR = 2'd2;

   typedef struct packed {
      logic [ALU_XLEN-1:0]  a;
      logic [ALU_XLEN-1:0]  b;
      logic [2:0]           op;
      logic                 shift_arith;
      logic [ALU_REG_W-1:0] rd_idx;
      logic                 rd_we;
   } alu_req_t;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-source forwarding mux: picks the youngest matching in-flight result,
// falling back to register-file data; x0 always reads as zero.
module alu_operand_stage_fwd_mux
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_IDX_W = 5
) (
   input  logic [REG_IDX_W-1:0] i_idx,
   input  logic [XLEN-1:0]      i_rf_data,
   input  logic                 i_ex_valid,
   input  logic [REG_IDX_W-1:0] i_ex_idx,
   input  logic [XLEN-1:0]      i_ex_data,
   input  logic                 i_mem_valid,
   input  logic [REG_IDX_W-1:0] i_mem_idx,
   input  logic [XLEN-1:0]      i_mem_data,
   output logic [XLEN-1:0]      o_data,
   output logic                 o_match_ex
);

   logic w_nonzero;
   logic w_match_mem;

   assign w_nonzero   = (i_idx != '0);
   assign o_match_ex  = i_ex_valid && (i_ex_idx == i_idx) && w_nonzero;
   assign w_match_mem = i_mem_valid && (i_mem_idx == i_idx) && w_nonzero;

   always_comb begin
      o_data = i_rf_data;
      if (!w_nonzero)
         o_data = '0;
      else if (o_match_ex)
         o_data = i_ex_data;
      else if (w_match_mem)
         o_data = i_mem_data;
   end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand select / forward / load-use stall stage feeding the ALU through a
// single registered entry with valid/ready handshakes on both sides.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_pc,
   input  logic [XLEN-1:0]      in_imm,
   input  logic [REG_IDX_W-1:0] in_rs1_idx,
   input  logic [REG_IDX_W-1:0] in_rs2_idx,
   input  logic [XLEN-1:0]      in_rs1_data,
   input  logic [XLEN-1:0]      in_rs2_data,
   input  logic [1:0]           in_sel_a,
   input  logic [1:0]           in_sel_b,
   input  logic [2:0]           in_alu_op,
   input  logic                 in_shift_arith,
   input  logic [REG_IDX_W-1:0] in_rd_idx,
   input  logic                 in_rd_we,
   input  logic                 fwd_ex_valid,
   input  logic [REG_IDX_W-1:0] fwd_ex_idx,
   input  logic [XLEN-1:0]      fwd_ex_data,
   input  logic                 fwd_ex_pending,
   input  logic                 fwd_mem_valid,
   input  logic [REG_IDX_W-1:0] fwd_mem_idx,
   input  logic [XLEN-1:0]      fwd_mem_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_a,
   output logic [XLEN-1:0]      out_b,
   output logic [2:0]           out_op,
   output logic                 out_shift_arith,
   output logic [REG_IDX_W-1:0] out_rd_idx,
   output logic                 out_rd_we,
   output logic [15:0]          stall_cnt
);

   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;
   logic            w_rs1_match_ex;
   logic            w_rs2_match_ex;
   logic            w_use_rs1;
   logic            w_use_rs2;
   logic            w_hazard;
   logic            w_accept;
   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_b;
   alu_req_t        w_req;

   logic            r_valid;
   alu_req_t        r_req;
   logic [15:0]     r_stall_cnt;

   alu_operand_stage_fwd_mux #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd_rs1 (
      .i_idx       (in_rs1_idx),
      .i_rf_data   (in_rs1_data),
      .i_ex_valid  (fwd_ex_valid),
      .i_ex_idx    (fwd_ex_idx),
      .i_ex_data   (fwd_ex_data),
      .i_mem_valid (fwd_mem_valid),
      .i_mem_idx   (fwd_mem_idx),
      .i_mem_data  (fwd_mem_data),
      .o_data      (w_rs1_data),
      .o_match_ex  (w_rs1_match_ex)
   );

   alu_operand_stage_fwd_mux #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd_rs2 (
      .i_idx       (in_rs2_idx),
      .i_rf_data   (in_rs2_data),
      .i_ex_valid  (fwd_ex_valid),
      .i_ex_idx    (fwd_ex_idx),
      .i_ex_data   (fwd_ex_data),
      .i_mem_valid (fwd_mem_valid),
      .i_mem_idx   (fwd_mem_idx),
      .i_mem_data  (fwd_mem_data),
      .o_data      (w_rs2_data),
      .o_match_ex  (w_rs2_match_ex)
   );

   // Only sources actually selected can stall; illegal selects read as zero.
   assign w_use_rs1 = (in_sel_a == SEL_A_RS1);
   assign w_use_rs2 = (in_sel_b == SEL_B_RS2);
   assign w_hazard  = in_valid && fwd_ex_pending &&
                      ((w_use_rs1 && w_rs1_match_ex) || (w_use_rs2 && w_rs2_match_ex));

   always_comb begin
      case (in_sel_a)
         SEL_A_RS1:  w_a = w_rs1_data;
         SEL_A_PC:   w_a = in_pc;
         default:    w_a = '0;
      endcase
      case (in_sel_b)
         SEL_B_RS2:  w_b = w_rs2_data;
         SEL_B_IMM:  w_b = in_imm;
         SEL_B_FOUR: w_b = XLEN'(4);
         default:    w_b = '0;
      endcase
   end

   always_comb begin
      w_req             = '0;
      w_req.a           = w_a;
      w_req.b           = w_b;
      w_req.op          = in_alu_op;
      w_req.shift_arith = in_shift_arith;
      w_req.rd_idx      = in_rd_idx;
      w_req.rd_we       = in_rd_we;
   end

   assign in_ready = rst_n && !flush && !w_hazard && (!r_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_req       <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (flush) begin
            r_valid     <= 1'b0;
            r_req.rd_we <= 1'b0;
         end else if (w_accept) begin
            r_valid <= 1'b1;
            r_req   <= w_req;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
         if (w_hazard && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign out_valid       = r_valid;
   assign out_a           = r_req.a;
   assign out_b           = r_req.b;
   assign out_op          = r_req.op;
   assign out_shift_arith = r_req.shift_arith;
   assign out_rd_idx      = r_req.rd_idx;
   assign out_rd_we       = r_req.rd_we;
   assign stall_cnt       = r_stall_cnt;

endmodule
